// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, RAM address, IR capture, branch loads and END halt.
// Optional FETCH_ALIGN_CHECK_EN flags misaligned PC loads and freezes fetch.
module instr_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 20,
  parameter int PC_STEP  = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_link,
  output logic              busy,
  output logic              halted,
  output logic              misalign_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] RPC  = ADDR_W'(RESET_PC);

  state_t            state, state_nx;
  logic              pend_v;
  logic [ADDR_W-1:0] pend_val;
  logic [ADDR_W-1:0] pc_inc;
  logic              ld_ok;
  logic              is_end;

  assign pc_inc   = pc + STEP;
  assign mem_addr = pc;
  assign is_end   = (mem_rdata[DATA_W-1 -: 4] == 4'b1100);

`ifdef FETCH_ALIGN_CHECK_EN
  logic ld_bad;
  assign ld_ok  = pc_load && (pc_load_val[1:0] == 2'b00);
  assign ld_bad = pc_load && (pc_load_val[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      misalign_err <= 1'b0;
    else if (ld_bad) misalign_err <= 1'b1;
  end
`else
  assign ld_ok        = pc_load;
  assign misalign_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (!pc_load && fetch_req && !halted && !misalign_err)
          state_nx = ADDR;
      end
      ADDR:    state_nx = LATCH;
      LATCH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // A load arriving in the LATCH cycle itself beats an older pending one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RPC;
      ir       <= '0;
      pc_link  <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
      pend_v   <= 1'b0;
      pend_val <= '0;
    end else begin
      ir_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ld_ok) pc <= pc_load_val;
        end
        ADDR: begin
          if (ld_ok) begin
            pend_v   <= 1'b1;
            pend_val <= pc_load_val;
          end
        end
        LATCH: begin
          ir       <= mem_rdata;
          pc_link  <= pc_inc;
          ir_valid <= 1'b1;
          pend_v   <= 1'b0;
          if (is_end) halted <= 1'b1;
          unique case (1'b1)
            ld_ok:   pc <= pc_load_val;
            pend_v:  pc <= pend_val;
            default: pc <= pc_inc;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: scoreboard of expected IR/link per fetch.
// Checks latency, back-to-back, loads, wrap, halt, reset and misalign.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic        pc_load;
  logic [7:0]  pc_load_val;
  logic [19:0] mem_rdata;
  logic [7:0]  mem_addr;
  logic [19:0] ir;
  logic        ir_valid;
  logic [7:0]  pc;
  logic [7:0]  pc_link;
  logic        busy;
  logic        halted;
  logic        misalign_err;

  logic [19:0] ram [256];
  logic [27:0] q [$];
  logic [27:0] mon_e;
  logic [7:0]  mpc;
  int          checks = 0;
  int          failures = 0;
  int          nvalid;

  instr_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_req    (fetch_req),
    .pc_load      (pc_load),
    .pc_load_val  (pc_load_val),
    .mem_rdata    (mem_rdata),
    .mem_addr     (mem_addr),
    .ir           (ir),
    .ir_valid     (ir_valid),
    .pc           (pc),
    .pc_link      (pc_link),
    .busy         (busy),
    .halted       (halted),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ir_valid) begin
      if (q.size() == 0) begin
        chk("spurious_valid", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("ir", 32'(ir), 32'(mon_e[27:8]));
        chk("pc_link", 32'(pc_link), 32'(mon_e[7:0]));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    mpc = 8'd0;
  endtask

  task automatic push_exp();
    q.push_back({ram[mpc], 8'(mpc + 8'd4)});
    mpc = mpc + 8'd4;
  endtask

  task automatic fetch_one();
    fetch_req = 1'b1;
    push_exp();
    @(negedge clk);
    fetch_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic load_idle(input logic [7:0] v);
    pc_load     = 1'b1;
    pc_load_val = v;
    @(negedge clk);
    pc_load = 1'b0;
    mpc     = v;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 20'($urandom);
      if (ram[i][19:16] == 4'hC) ram[i][19] = 1'b0;
    end
    ram[0]  = 20'h40950;
    ram[32] = 20'hC0000;
    rst_n       = 1'b0;
    fetch_req   = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = '0;
    mpc         = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_link", 32'(pc_link), 32'd0);
    chk("rst_valid", 32'(ir_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single fetch, latency N+2
    fetch_req = 1'b1;
    push_exp();
    @(negedge clk);
    fetch_req = 1'b0;
    chk("t1_busy_n", 32'(busy), 32'd1);
    chk("t1_valid_n", 32'(ir_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid_n1", 32'(ir_valid), 32'd0);
    chk("t1_ir_n1", 32'(ir), 32'd0);
    @(negedge clk);
    chk("t1_valid_n2", 32'(ir_valid), 32'd1);
    chk("t1_ir_n2", 32'(ir), 32'h40950);
    chk("t1_pc", 32'(pc), 32'd4);
    chk("t1_busy_n2", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t1_valid_pulse", 32'(ir_valid), 32'd0);

    // back-to-back from 0
    do_reset();
    fetch_req = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 9; i++) begin
      if (i % 3 == 0) push_exp();
      @(negedge clk);
      if (ir_valid) nvalid++;
    end
    fetch_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("t2_nvalid", 32'(nvalid), 32'd3);
    chk("t2_pc", 32'(pc), 32'd12);

    // load wins in IDLE, pending load during ADDR
    fetch_req = 1'b1;
    load_idle(8'd40);
    fetch_req = 1'b0;
    chk("t3_pc40", 32'(pc), 32'd40);
    chk("t3_idle", 32'(busy), 32'd0);
    fetch_req = 1'b1;
    push_exp();
    @(negedge clk);
    fetch_req   = 1'b0;
    chk("t3_busy", 32'(busy), 32'd1);
    pc_load     = 1'b1;
    pc_load_val = 8'd80;
    @(negedge clk);
    pc_load = 1'b0;
    chk("t3_pc_held", 32'(pc), 32'd40);
    @(negedge clk);
    chk("t3_pc80", 32'(pc), 32'd80);
    mpc = 8'd80;
    @(negedge clk);

    // wraparound
    load_idle(8'd252);
    fetch_one();
    chk("t4_pc_wrap", 32'(pc), 32'd0);

    // END opcode halt
    load_idle(8'd32);
    fetch_one();
    chk("t5_halted", 32'(halted), 32'd1);
    fetch_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_busy", 32'(busy), 32'd0);
    end
    fetch_req = 1'b0;
    load_idle(8'd8);
    chk("t5_load_halted", 32'(pc), 32'd8);

    // reset during LATCH
    do_reset();
    chk("t6_unhalt", 32'(halted), 32'd0);
    fetch_one();
    load_idle(8'd16);
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    chk("t6_in_latch", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_ir", 32'(ir), 32'd0);
    chk("t6_pc", 32'(pc), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mpc = 8'd0;
    @(negedge clk);

    // misaligned load
    load_idle(8'd42);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("t6_misalign", 32'(misalign_err), 32'd1);
    chk("t6_pc_kept", 32'(pc), 32'd0);
    fetch_req = 1'b1;
    repeat (3) @(negedge clk);
    fetch_req = 1'b0;
    chk("t6_no_fetch", 32'(busy), 32'd0);
`else
    chk("t6_misalign", 32'(misalign_err), 32'd0);
    chk("t6_pc_42", 32'(pc), 32'd42);
`endif
    repeat (2) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
